key_en_ctrl: RTL

- Generates the LED enable from a physical push-button. This is the driving end of the `en` interface that the LED controller consumes.
- Synchronises and debounces the raw key, then toggles `en` once per debounced press.
- Also emits a one-cycle press strobe and the debounced key level.
- Sits between the board key pin and the LED controller's `en` input.

---
 rtl/key_pkg.sv | 17 +
 rtl/key_en_if.sv | 13 +
 rtl/sync_2ff.sv | 29 ++
 rtl/key_en_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key-to-enable path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_pkg;

  // Debounce FSM encoding; values are visible in waveforms, so keep them fixed.
  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_FILTER   = 2'd1,
    PRESSED        = 2'd2,
    RELEASE_FILTER = 2'd3
  } key_state_t;

  // 20 ms of stable level at a 50 MHz system clock.
  localparam int unsigned DEBOUNCE_50MHZ = 1_000_000;

endpackage

// File: rtl/key_en_if.sv
// Enable bundle driven by the key controller and consumed by the LED controller.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must sample every cycle.
interface key_en_if;

  logic en;         // LED enable, toggles once per accepted press
  logic key_pulse;  // one-cycle strobe per accepted press
  logic key_level;  // debounced key state, 1 = pressed

  modport master (output en, output key_pulse, output key_level);
  modport slave  (input  en, input  key_pulse, input  key_level);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Latency: 2 clock edges from input change to output change.
// Backpressure: none.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Reset loads the idle level so deassertion never looks like an input edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_en_ctrl.sv
// Debounces a push-button and toggles the LED enable once per accepted press.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling of a new key level to outputs.
// Backpressure: none; all outputs are registered and free-running.
module key_en_ctrl
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_50MHZ,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter bit          EN_INIT         = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  key_en_if.master   en_if
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_0   = '0;

  // Released level of the raw pin, used as the synchroniser reset value.
  localparam logic KEY_IDLE = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic        w_key_raw;
  logic        w_key_s;

  key_state_t  r_state;
  key_state_t  w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic        r_en;
  logic        w_en_nxt;
  logic        r_pulse;
  logic        w_pulse_nxt;
  logic        r_level;
  logic        w_level_nxt;

  sync_2ff #(
    .RST_VAL (KEY_IDLE)
  ) u_sync (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (key_in),
    .o_q   (w_key_raw)
  );

  // Normalise polarity after the synchroniser: 1 always means pressed.
  assign w_key_s = KEY_ACTIVE_LOW ? ~w_key_raw : w_key_raw;

  // Next-state and registered-output decode for the debounce FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        if (w_key_s) begin
          w_state_nxt = PRESS_FILTER;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_FILTER: begin
        if (!w_key_s) begin
          // Level did not hold long enough: treat as bounce.
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = CNT_0;
          w_pulse_nxt = 1'b1;
          w_en_nxt    = ~r_en;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        // Holding is silent; no auto-repeat.
        if (!w_key_s) begin
          w_state_nxt = RELEASE_FILTER;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_FILTER: begin
        if (w_key_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = CNT_0;
        end else if (r_cnt == CNT_MAX) begin
          // Release only drops the level; enable is press-driven.
          w_state_nxt = IDLE;
          w_cnt_nxt   = CNT_0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CNT_0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any partial filtering.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_cnt   <= CNT_0;
      r_en    <= EN_INIT;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_en_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  assign en_if.en        = r_en;
  assign en_if.key_pulse = r_pulse;
  assign en_if.key_level = r_level;

endmodule
